// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its fetch and load/store requesters, and the data memory port.
// The slave view belongs to the arbiter; the master view to whatever drives requests and memory data.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [1:0]        dm_size;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_re, mem_we, mem_addr, mem_wdata, mem_size
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_re, mem_we, mem_addr, mem_wdata, mem_size
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one data memory port between fetch and load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise load/store always wins a tie.
//
// state   | meaning
// IDLE    | no transaction outstanding
// WAIT_IF | fetch read outstanding, response when latCnt reaches 1
// WAIT_DM | load or store outstanding, response when latCnt reaches 1
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_t;

  state_t            state, stateNext;
  logic [3:0]        latCnt;
  logic              lastDm;
  logic [ADDR_W-1:0] lastAddr;
  logic [DATA_W-1:0] lastWdata;
  logic [1:0]        lastSize;
  logic              respCycle, arbOpen, pickDm, grant, grantDm;

  always_comb begin
    respCycle = (state != IDLE) && (latCnt == 4'd1) && !reset;
    arbOpen   = !reset && ((state == IDLE) || respCycle);
`ifdef MEM_ARB_RR_EN
    pickDm    = !lastDm;
`else
    // Fixed priority: the last-winner register is still maintained but has no say.
    pickDm    = 1'b1 | lastDm;
`endif
    grant     = arbOpen && (bus.if_req || bus.dm_req);
    grantDm   = bus.dm_req && (!bus.if_req || pickDm);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = lastAddr;
    bus.mem_wdata = lastWdata;
    bus.mem_size  = lastSize;
    if (respCycle) begin
      if (state == WAIT_IF) bus.if_rvalid = 1'b1;
      else                  bus.dm_rvalid = 1'b1;
      stateNext = IDLE;
    end
    if (grant) begin
      if (grantDm) begin
        bus.dm_gnt    = 1'b1;
        bus.mem_re    = !bus.dm_we;
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
        bus.mem_size  = bus.dm_size;
        stateNext     = WAIT_DM;
      end else begin
        bus.if_gnt    = 1'b1;
        bus.mem_re    = 1'b1;
        bus.mem_addr  = bus.if_addr;
        bus.mem_wdata = '0;
        bus.mem_size  = 2'b11;
        stateNext     = WAIT_IF;
      end
    end
    if (reset) begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_size  = '0;
    end
  end

  assign bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata = bus.dm_rvalid ? bus.mem_rdata : '0;

  // Counter only matters while a transaction is outstanding; it idles at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      latCnt    <= '0;
      lastDm    <= 1'b0;
      lastAddr  <= '0;
      lastWdata <= '0;
      lastSize  <= '0;
    end else if (grant) begin
      latCnt    <= LAT;
      lastDm    <= grantDm;
      lastAddr  <= bus.mem_addr;
      lastWdata <= bus.mem_wdata;
      lastSize  <= bus.mem_size;
    end else if (latCnt != 4'd0) begin
      latCnt    <= latCnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 and 3) share one directed stimulus and are
// checked every cycle against a transaction-level model, plus hand-computed spot checks.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        ifGnt, dmGnt, ifRvalid, dmRvalid, memRe, memWe;
    logic [31:0] ifRdata, dmRdata, memAddr, memWdata;
    logic [1:0]  memSize;
  } outs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic        dmReq = 1'b0;
  logic        dmWe = 1'b0;
  logic [31:0] dmAddr = '0;
  logic [31:0] dmWdata = '0;
  logic [1:0]  dmSize = '0;
  logic [31:0] memRdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus3 ();

  assign bus1.if_req = ifReq;   assign bus3.if_req = ifReq;
  assign bus1.if_addr = ifAddr; assign bus3.if_addr = ifAddr;
  assign bus1.dm_req = dmReq;   assign bus3.dm_req = dmReq;
  assign bus1.dm_we = dmWe;     assign bus3.dm_we = dmWe;
  assign bus1.dm_addr = dmAddr; assign bus3.dm_addr = dmAddr;
  assign bus1.dm_wdata = dmWdata; assign bus3.dm_wdata = dmWdata;
  assign bus1.dm_size = dmSize; assign bus3.dm_size = dmSize;
  assign bus1.mem_rdata = memRdata; assign bus3.mem_rdata = memRdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  outs_t g1, g3;
  assign g1 = {bus1.if_gnt, bus1.dm_gnt, bus1.if_rvalid, bus1.dm_rvalid, bus1.mem_re, bus1.mem_we,
               bus1.if_rdata, bus1.dm_rdata, bus1.mem_addr, bus1.mem_wdata, bus1.mem_size};
  assign g3 = {bus3.if_gnt, bus3.dm_gnt, bus3.if_rvalid, bus3.dm_rvalid, bus3.mem_re, bus3.mem_we,
               bus3.if_rdata, bus3.dm_rdata, bus3.mem_addr, bus3.mem_wdata, bus3.mem_size};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Model state: one outstanding transaction per instance, completing at an absolute cycle.
  int          lat [2] = '{1, 3};
  bit          mBusy [2];
  int          mRespAt [2];
  bit          mOwnerDm [2];
  bit          mLastDm [2];
  logic [31:0] mAddr [2];
  logic [31:0] mWdata [2];

  task automatic modelStep(input int k, input outs_t g);
    string  s;
    bit     resp, open, gnt, dmWin;
    logic [31:0] eAddr, eWdata;
    s = $sformatf("L%0d", lat[k]);
    if (reset) begin
      cmp({"rst_outs_", s}, {26'd0, g.ifGnt, g.dmGnt, g.ifRvalid, g.dmRvalid, g.memRe, g.memWe}, 32'd0);
      cmp({"rst_addr_", s}, g.memAddr, 32'd0);
      cmp({"rst_wdata_", s}, g.memWdata, 32'd0);
      cmp({"rst_rdata_", s}, g.ifRdata | g.dmRdata | {30'd0, g.memSize}, 32'd0);
      mBusy[k] = 1'b0;
      mLastDm[k] = 1'b0;
      mAddr[k] = '0;
      mWdata[k] = '0;
      return;
    end
    resp  = mBusy[k] && (mRespAt[k] == cyc);
    open  = !mBusy[k] || resp;
    gnt   = open && (ifReq || dmReq);
    dmWin = dmReq && (!ifReq || (RR ? !mLastDm[k] : 1'b1));
    eAddr  = gnt ? (dmWin ? dmAddr : ifAddr) : mAddr[k];
    eWdata = gnt ? (dmWin ? dmWdata : 32'd0) : mWdata[k];
    cmp({"if_gnt_", s}, {31'd0, g.ifGnt}, {31'd0, gnt && !dmWin});
    cmp({"dm_gnt_", s}, {31'd0, g.dmGnt}, {31'd0, gnt && dmWin});
    cmp({"mem_re_", s}, {31'd0, g.memRe}, {31'd0, gnt && (!dmWin || !dmWe)});
    cmp({"mem_we_", s}, {31'd0, g.memWe}, {31'd0, gnt && dmWin && dmWe});
    cmp({"mem_addr_", s}, g.memAddr, eAddr);
    cmp({"mem_wdata_", s}, g.memWdata, eWdata);
    if (gnt) cmp({"mem_size_", s}, {30'd0, g.memSize}, {30'd0, dmWin ? dmSize : 2'b11});
    cmp({"if_rvalid_", s}, {31'd0, g.ifRvalid}, {31'd0, resp && !mOwnerDm[k]});
    cmp({"dm_rvalid_", s}, {31'd0, g.dmRvalid}, {31'd0, resp && mOwnerDm[k]});
    if (resp && !mOwnerDm[k]) cmp({"if_rdata_", s}, g.ifRdata, memRdata);
    if (resp && mOwnerDm[k])  cmp({"dm_rdata_", s}, g.dmRdata, memRdata);
    if (gnt) begin
      mBusy[k]    = 1'b1;
      mRespAt[k]  = cyc + lat[k];
      mOwnerDm[k] = dmWin;
      mLastDm[k]  = dmWin;
      mAddr[k]    = eAddr;
      mWdata[k]   = eWdata;
    end else if (resp) begin
      mBusy[k] = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    modelStep(0, g1);
    modelStep(1, g3);
    cyc++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset with both requests pending: nothing may be granted until reset drops.
    ifReq = 1'b1; ifAddr = 32'h0040_0100;
    dmReq = 1'b1; dmAddr = 32'h1000_0100;
    idle(3);
    #3;
    cmp("lit_rst_gnt", {30'd0, bus1.if_gnt, bus1.dm_gnt}, 32'd0);
    cmp("lit_rst_addr", bus3.mem_addr, 32'd0);
    tick(); reset = 1'b0;
    #3;
    cmp("lit_first_tie_dm", {30'd0, bus1.if_gnt, bus1.dm_gnt}, 32'd1);
    tick(); ifReq = 1'b0; dmReq = 1'b0;
    idle(5);

    // Fetch read alone.
    memRdata = 32'h2008_0005;
    ifReq = 1'b1; ifAddr = 32'h0040_0000;
    #3;
    cmp("lit_if_gnt", {31'd0, bus1.if_gnt}, 32'd1);
    cmp("lit_if_addr", bus1.mem_addr, 32'h0040_0000);
    cmp("lit_if_size", {30'd0, bus1.mem_size}, 32'd3);
    tick(); ifReq = 1'b0;
    #3;
    cmp("lit_if_rvalid_l1", {30'd0, bus1.if_rvalid, bus1.dm_rvalid}, 32'd2);
    cmp("lit_if_rdata_l1", bus1.if_rdata, 32'h2008_0005);
    idle(2);
    #3;
    cmp("lit_if_rvalid_l3", {31'd0, bus3.if_rvalid}, 32'd1);
    idle(4);

    // Store with latency 3 while fetch waits.
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h1000_0010; dmWdata = 32'hDEAD_BEEF; dmSize = 2'b10;
    #3;
    cmp("lit_st_we", {30'd0, bus3.mem_we, bus3.mem_re}, 32'd2);
    cmp("lit_st_addr", bus3.mem_addr, 32'h1000_0010);
    cmp("lit_st_wdata", bus3.mem_wdata, 32'hDEAD_BEEF);
    tick(); dmReq = 1'b0; dmWe = 1'b0; ifReq = 1'b1; ifAddr = 32'h0040_0004;
    #3;
    cmp("lit_st_we_once", {31'd0, bus3.mem_we}, 32'd0);
    cmp("lit_st_if_wait1", {31'd0, bus3.if_gnt}, 32'd0);
    tick();
    #3;
    cmp("lit_st_if_wait2", {31'd0, bus3.if_gnt}, 32'd0);
    tick();
    #3;
    cmp("lit_st_done_gnt", {30'd0, bus3.dm_rvalid, bus3.if_gnt}, 32'd3);
    tick(); ifReq = 1'b0;
    idle(5);

    // Sustained contention for six cycles.
    ifReq = 1'b1; ifAddr = 32'h0040_0020;
    dmReq = 1'b1; dmAddr = 32'h1000_0020;
    for (int i = 0; i < 6; i++) begin
      #3;
      cmp($sformatf("lit_tie_%0d", i), {30'd0, bus1.if_gnt, bus1.dm_gnt},
          (RR && (i % 2 == 1)) ? 32'd2 : 32'd1);
      tick();
    end
    ifReq = 1'b0; dmReq = 1'b0;
    idle(5);

    // Back-to-back load then fetch with latency 1.
    dmReq = 1'b1; dmAddr = 32'h1000_0030;
    tick(); dmReq = 1'b0; ifReq = 1'b1; ifAddr = 32'h0040_0008; memRdata = 32'h1111_2222;
    #3;
    cmp("lit_b2b_overlap", {30'd0, bus1.dm_rvalid, bus1.if_gnt}, 32'd3);
    cmp("lit_b2b_dm_rdata", bus1.dm_rdata, 32'h1111_2222);
    tick(); ifReq = 1'b0; memRdata = 32'h3333_4444;
    #3;
    cmp("lit_b2b_if_rvalid", {30'd0, bus1.if_rvalid, bus1.dm_rvalid}, 32'd2);
    cmp("lit_b2b_if_rdata", bus1.if_rdata, 32'h3333_4444);
    idle(5);

    // Reset in the middle of an outstanding latency-3 load.
    dmReq = 1'b1; dmAddr = 32'h1000_0040;
    #3;
    cmp("lit_abort_gnt", {31'd0, bus3.dm_gnt}, 32'd1);
    tick(); reset = 1'b1;
    #3;
    cmp("lit_abort_rst_outs", {28'd0, bus3.dm_gnt, bus3.mem_re, bus3.dm_rvalid, bus1.dm_gnt}, 32'd0);
    tick();
    tick(); reset = 1'b0;
    #3;
    cmp("lit_abort_regnt", {30'd0, bus3.dm_gnt, bus3.dm_rvalid}, 32'd2);
    tick(); dmReq = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single data_memory port between instruction fetch and the load/store stage of the pipelined processor. It accepts one transaction at a time and drives the memory control, address and data lines for it. It tracks the fixed memory read latency and returns read data and a completion pulse to the owning requester. Arbitration is either round-robin or fixed data-priority, selected at compile time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from grant to read data valid; legal range 1..15
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  load/store request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  load/store address
- dm_wdata  in  DATA_W  store data
- dm_size  in  2  access size, passed through
- dm_gnt  out  1  load/store accepted this cycle
- dm_rvalid  out  1  load data valid, or store complete
- dm_rdata  out  DATA_W  load data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_size  out  2  memory access size
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_re

## Operation
- State: pending flag, owner bit (0 = IF, 1 = DM), latency counter of 4 bits, last-winner bit.
- Arbitration is open when pending = 0, or when the current cycle is the pending transaction's response cycle.
- When open and at least one req is high, exactly one grant is issued combinationally in that cycle:
  - Only one req high: that requester wins.
  - Both high: with MEM_ARB_RR_EN, the requester that did not win last time wins. Without it, DM wins.
- On grant:
  - mem_re = 1 for IF or for a DM load; mem_we = dm_we for DM.
  - mem_addr, mem_wdata and mem_size come from the winner. For IF, mem_size = 2'b11 and mem_wdata = 0.
  - At the clock edge: pending <= 1, owner <= winner, counter loaded with MEM_LAT, last-winner updated.
- When no grant is issued: mem_re = mem_we = 0, mem_addr/mem_wdata hold the last granted values.
- Response cycle: exactly MEM_LAT cycles after the grant cycle, the owner's rvalid = 1 for one cycle and rdata = mem_rdata.
  - A store also produces the dm_rvalid pulse; dm_rdata is don't-care for stores.
  - The non-owner's rvalid stays 0.
- Response and new grant in the same cycle: pending stays 1 with the new owner. Otherwise pending <= 0 after the response.
- Requester rules:
  - req, addr, wdata, we and size must be held stable until gnt.
  - The requester may drop or change them in the cycle after gnt.
  - A req that is dropped before gnt is simply never granted.
- rdata is valid only while rvalid = 1.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req when arbitration is open.
- Read latency is MEM_LAT cycles from gnt to rvalid.
- Peak throughput is one transaction per MEM_LAT cycles. With MEM_LAT = 1, back-to-back grants occur every cycle.
- Reset values: if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_re, mem_we = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; mem_size = 0.
- Reset clears pending and sets last-winner = IF, so DM wins the first tie in both modes.
- While reset = 1, all grants are suppressed.
- Reset during an outstanding transaction abandons it: no rvalid is issued afterwards.
- A req held high through the reset deassertion is granted in the first cycle after reset = 0.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests, which alternates IF/DM under sustained contention.
- MEM_ARB_RR_EN undefined: fixed DM priority. IF can starve while dm_req stays high. The last-winner register is still present but ignored.

## Test plan
- MEM_LAT = 1, IF reads 0x0040_0000 alone with mem_rdata = 0x2008_0005 -> if_gnt in cycle T, if_rvalid in T+1 with if_rdata = 0x2008_0005, dm_rvalid = 0.
- MEM_LAT = 3, DM store to 0x1000_0010 with data 0xDEAD_BEEF -> mem_we = 1 for exactly one cycle with that address and data; dm_rvalid at T+3; an IF req raised at T+1 gets no grant until T+3.
- Both reqs held high for 6 cycles, MEM_LAT = 1, RR_EN defined -> grants DM, IF, DM, IF, DM, IF; without RR_EN -> DM on all 6 cycles.
- Back-to-back: DM load at T, IF request at T+1, MEM_LAT = 1 -> dm_rvalid and if_gnt both high in cycle T+1; if_rvalid at T+2.
- Reset asserted one cycle after a DM load grant with MEM_LAT = 3 -> no dm_rvalid ever issued; all outputs 0 during reset; a held dm_req is granted in the first cycle after reset deasserts.
